// File: rtl/state_history_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : state_history_logger_if
// Purpose  : Read-back port of the state history logger. The debug host
//            supplies an age index and receives the registered entry fields.
// Revision : 1.0 - initial release
// ============================================================================
interface state_history_logger_if #(
  parameter int BITS    = 8,
  parameter int DEPTH   = 8,
  parameter int TS_BITS = 16
);
  logic [$clog2(DEPTH)-1:0] iRdIdx;
  logic [BITS-1:0]          oRdState;
  logic [TS_BITS-1:0]       oRdDwell;
  logic                     oRdValid;

  // Debug host side: selects an entry, observes the result
  modport master (output iRdIdx, input oRdState, input oRdDwell, input oRdValid);
  // Logger side: serves the selected entry
  modport slave  (input iRdIdx, output oRdState, output oRdDwell, output oRdValid);
endinterface
`default_nettype wire

// File: rtl/state_history_logger.sv
`default_nettype none
// ============================================================================
// Module   : state_history_logger
// Purpose  : Records every change of a debug state bus into a circular
//            history of {state left, dwell cycles}; entries are read back by
//            age index through a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module state_history_logger #(
  parameter int BITS         = 8,
  parameter int DEPTH        = 8,
  parameter int TS_BITS      = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  wire logic                     iClk,
  input  wire logic                     iRst_n,
  input  wire logic                     iClear,
  input  wire logic                     iEnable,
  input  wire logic                     iFreeze,
  input  wire logic [BITS-1:0]          iDbgSt,
  state_history_logger_if.slave         rd,
  output logic      [BITS-1:0]          current_state,
  output logic      [BITS-1:0]          prev_state,
  output logic      [$clog2(DEPTH):0]   oCount,
  output logic      [7:0]               oLost,
  output logic                          ochange
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int ENT_W = BITS + TS_BITS;
  localparam logic [TS_BITS-1:0] DWELL_MAX = {TS_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               fsm_q, fsm_d;
  logic [BITS-1:0]      cur_q, cur_d;
  logic [BITS-1:0]      prev_q, prev_d;
  logic [TS_BITS-1:0]   dwell_q, dwell_d;
  logic [IDX_W-1:0]     wp_q, wp_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [7:0]           lost_q, lost_d;
  logic                 change_q, change_d;
  logic                 wr_en;

  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic                 rd_valid_q;
  logic [BITS-1:0]      rd_state_q;
  logic [TS_BITS-1:0]   rd_dwell_q;

  logic [IDX_W-1:0]     rd_slot;
  logic                 rd_hit;
  logic [7:0]           lost_inc;

  assign rd_slot  = wp_q - IDX_W'(1) - rd.iRdIdx;
  assign rd_hit   = {1'b0, rd.iRdIdx} < count_q;
  assign lost_inc = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

  // Next-state logic: FSM, state tracking, dwell and history bookkeeping
  always_comb begin
    fsm_d    = fsm_q;
    cur_d    = cur_q;
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    wp_d     = wp_q;
    count_d  = count_q;
    lost_d   = lost_q;
    change_d = change_q;
    wr_en    = 1'b0;
    if (!iClear) begin
      fsm_d    = ST_INIT;
      cur_d    = '0;
      prev_d   = '0;
      dwell_d  = '0;
      wp_d     = '0;
      count_d  = '0;
      lost_d   = '0;
      change_d = 1'b0;
    end else if (iEnable) begin
      case (fsm_q)
        ST_INIT: begin
          // First enabled edge only captures the starting state
          cur_d   = iDbgSt;
          dwell_d = TS_BITS'(1);
          fsm_d   = ST_RUN;
        end
        ST_RUN: begin
          if (iDbgSt == cur_q) begin
            if (dwell_q != DWELL_MAX) dwell_d = dwell_q + TS_BITS'(1);
          end else begin
            prev_d   = cur_q;
            cur_d    = iDbgSt;
            dwell_d  = TS_BITS'(1);
            change_d = 1'b1;
            if (iFreeze) begin
              lost_d = lost_inc;
            end else if (count_q < CNT_W'(DEPTH)) begin
              wr_en   = 1'b1;
              wp_d    = wp_q + IDX_W'(1);
              count_d = count_q + CNT_W'(1);
            end else if (STOP_ON_FULL == 0) begin
              // Full and wrapping: the oldest entry is overwritten
              wr_en  = 1'b1;
              wp_d   = wp_q + IDX_W'(1);
              lost_d = lost_inc;
            end else begin
              lost_d = lost_inc;
            end
          end
        end
        default: fsm_d = ST_INIT;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fsm_q    <= ST_INIT;
      cur_q    <= '0;
      prev_q   <= '0;
      dwell_q  <= '0;
      wp_q     <= '0;
      count_q  <= '0;
      lost_q   <= '0;
      change_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      dwell_q  <= dwell_d;
      wp_q     <= wp_d;
      count_q  <= count_d;
      lost_q   <= lost_d;
      change_q <= change_d;
    end
  end

  // History storage; contents are qualified by the valid count, not reset
  always_ff @(posedge iClk) begin
    if (wr_en) mem_q[wp_q] <= {cur_q, dwell_q};
  end

  // Registered read port; sees memory before any same-edge write
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_valid_q <= 1'b0;
      rd_state_q <= '0;
      rd_dwell_q <= '0;
    end else if (iEnable) begin
      rd_valid_q <= rd_hit;
      if (rd_hit) begin
        {rd_state_q, rd_dwell_q} <= mem_q[rd_slot];
      end else begin
        rd_state_q <= '0;
        rd_dwell_q <= '0;
      end
    end
  end

  assign current_state = cur_q;
  assign prev_state    = prev_q;
  assign oCount        = count_q;
  assign oLost         = lost_q;
  assign ochange       = change_q;
  assign rd.oRdValid   = rd_valid_q;
  assign rd.oRdState   = rd_state_q;
  assign rd.oRdDwell   = rd_dwell_q;

endmodule
`default_nettype wire

// File: tb/tb_state_history_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_state_history_logger
// Purpose  : Directed bench for state_history_logger; one wrapping and one
//            stop-on-full instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_state_history_logger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       frz = 1'b0;
  logic [7:0] dbg = 8'h00;
  logic [2:0] rd_idx = 3'd0;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] w_cur, w_prev, w_lost, s_cur, s_prev, s_lost;
  logic [3:0] w_cnt, s_cnt;
  logic       w_chg, s_chg;

  always #5 clk = ~clk;

  state_history_logger_if #(.BITS(8), .DEPTH(8), .TS_BITS(16)) if_w ();
  state_history_logger_if #(.BITS(8), .DEPTH(8), .TS_BITS(16)) if_s ();
  assign if_w.iRdIdx = rd_idx;
  assign if_s.iRdIdx = rd_idx;

  state_history_logger #(.BITS(8), .DEPTH(8), .TS_BITS(16), .STOP_ON_FULL(0)) u_wrap (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr), .iEnable(en), .iFreeze(frz),
    .iDbgSt(dbg), .rd(if_w.slave), .current_state(w_cur), .prev_state(w_prev),
    .oCount(w_cnt), .oLost(w_lost), .ochange(w_chg)
  );

  state_history_logger #(.BITS(8), .DEPTH(8), .TS_BITS(16), .STOP_ON_FULL(1)) u_stop (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr), .iEnable(en), .iFreeze(frz),
    .iDbgSt(dbg), .rd(if_s.slave), .current_state(s_cur), .prev_state(s_prev),
    .oCount(s_cnt), .oLost(s_lost), .ochange(s_chg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cur", 32'(w_cur), 32'h0);
    chk("rst_prev", 32'(w_prev), 32'h0);
    chk("rst_cnt", 32'(w_cnt), 32'h0);
    chk("rst_lost", 32'(w_lost), 32'h0);
    chk("rst_chg", 32'(w_chg), 32'h0);
    chk("rst_rdvalid", 32'(if_w.oRdValid), 32'h0);
    rst_n = 1'b1;

    // Hold 0x01 for five enabled edges, then move to 0x02
    en = 1'b1; dbg = 8'h01;
    repeat (5) tick();
    chk("init_chg", 32'(w_chg), 32'h0);
    chk("init_cnt", 32'(w_cnt), 32'h0);
    dbg = 8'h02;
    tick();
    chk("t1_cur", 32'(w_cur), 32'h02);
    chk("t1_prev", 32'(w_prev), 32'h01);
    chk("t1_chg", 32'(w_chg), 32'h1);
    chk("t1_cnt", 32'(w_cnt), 32'h1);
    tick();
    chk("t1_rdvalid", 32'(if_w.oRdValid), 32'h1);
    chk("t1_rdstate", 32'(if_w.oRdState), 32'h01);
    chk("t1_rddwell", 32'(if_w.oRdDwell), 32'h5);

    // Nine more transitions: entries {2,2},{3,1}..{10,1}; live state 11
    for (int s = 3; s <= 11; s++) begin
      dbg = 8'(s);
      tick();
    end
    chk("wrap_cnt", 32'(w_cnt), 32'h8);
    chk("wrap_lost", 32'(w_lost), 32'h2);
    chk("stop_cnt", 32'(s_cnt), 32'h8);
    chk("stop_lost", 32'(s_lost), 32'h2);
    chk("stop_cur", 32'(s_cur), 32'h0B);

    rd_idx = 3'd7;
    tick();
    chk("wrap_idx7_state", 32'(if_w.oRdState), 32'h03);
    chk("wrap_idx7_dwell", 32'(if_w.oRdDwell), 32'h1);
    chk("stop_idx7_state", 32'(if_s.oRdState), 32'h01);
    chk("stop_idx7_dwell", 32'(if_s.oRdDwell), 32'h5);
    rd_idx = 3'd0;
    tick();
    chk("wrap_idx0_state", 32'(if_w.oRdState), 32'h0A);
    chk("stop_idx0_state", 32'(if_s.oRdState), 32'h08);
    chk("stop_idx0_valid", 32'(if_s.oRdValid), 32'h1);

    // Frozen transition is dropped and counted as lost
    frz = 1'b1; dbg = 8'h0C;
    tick();
    frz = 1'b0;
    chk("frz_lost", 32'(w_lost), 32'h3);
    chk("frz_cnt", 32'(s_cnt), 32'h8);
    chk("frz_cur", 32'(w_cur), 32'h0C);

    // Clear coincident with a transition wins
    clr = 1'b0; dbg = 8'h0D;
    tick();
    chk("clr_cnt", 32'(w_cnt), 32'h0);
    chk("clr_chg", 32'(w_chg), 32'h0);
    chk("clr_lost", 32'(s_lost), 32'h0);
    chk("clr_cur", 32'(w_cur), 32'h0);
    clr = 1'b1; dbg = 8'h20;
    tick();
    chk("recap_cur", 32'(w_cur), 32'h20);
    chk("recap_chg", 32'(w_chg), 32'h0);
    chk("recap_cnt", 32'(w_cnt), 32'h0);
    chk("empty_rdvalid", 32'(if_w.oRdValid), 32'h0);
    chk("empty_rdstate", 32'(if_w.oRdState), 32'h0);

    // One entry {0x20,1}; index 1 is beyond the valid count
    dbg = 8'h21; rd_idx = 3'd1;
    tick();
    tick();
    chk("oob_rdvalid", 32'(if_w.oRdValid), 32'h0);
    chk("oob_rdstate", 32'(if_w.oRdState), 32'h0);
    chk("oob_rddwell", 32'(if_w.oRdDwell), 32'h0);

    // Disabled: toggling input changes nothing
    en = 1'b0; dbg = 8'h55;
    tick();
    dbg = 8'h66;
    tick();
    chk("dis_cur", 32'(w_cur), 32'h21);
    chk("dis_prev", 32'(w_prev), 32'h20);
    chk("dis_cnt", 32'(w_cnt), 32'h1);
    chk("dis_chg", 32'(w_chg), 32'h1);

    // Dwell saturation
    en = 1'b1; dbg = 8'h21; rd_idx = 3'd0;
    repeat (70000) @(posedge clk);
    #1;
    dbg = 8'h22;
    tick();
    chk("sat_cnt", 32'(w_cnt), 32'h2);
    tick();
    chk("sat_rdstate", 32'(if_w.oRdState), 32'h21);
    chk("sat_rddwell", 32'(if_w.oRdDwell), 32'hFFFF);

    // Asynchronous reset during an in-flight transition
    dbg = 8'h30;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(w_cnt), 32'h0);
    chk("arst_cur", 32'(w_cur), 32'h0);
    chk("arst_rdvalid", 32'(if_w.oRdValid), 32'h0);
    tick();
    chk("arst_hold_cnt", 32'(w_cnt), 32'h0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
